// File: rtl/inst_decode_pkg.sv
// Shared encodings for the decode stage: opcodes, R-type functs, ALU control codes
// and the control-bit bundle produced by the decode table.
package inst_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_wr;
    logic       mem_wr;
    logic       branch;
    logic       ext_op;
    logic [2:0] alu_ctr;
  } ctrl_t;

  // Anything outside the table decodes to an all-zero bubble.
  function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin c.reg_dst = 1'b1; c.reg_wr = 1'b1; c.alu_ctr = ALU_ADD; end
          FN_SUB:  begin c.reg_dst = 1'b1; c.reg_wr = 1'b1; c.alu_ctr = ALU_SUB; end
          FN_AND:  begin c.reg_dst = 1'b1; c.reg_wr = 1'b1; c.alu_ctr = ALU_AND; end
          FN_OR:   begin c.reg_dst = 1'b1; c.reg_wr = 1'b1; c.alu_ctr = ALU_OR;  end
          FN_SLT:  begin c.reg_dst = 1'b1; c.reg_wr = 1'b1; c.alu_ctr = ALU_SLT; end
          default: c = '0;
        endcase
      end
      OP_ORI: begin c.alu_src = 1'b1; c.reg_wr = 1'b1; c.alu_ctr = ALU_OR; end
      OP_LW: begin
        c.alu_src = 1'b1; c.mem_to_reg = 1'b1; c.reg_wr = 1'b1;
        c.ext_op  = 1'b1; c.alu_ctr = ALU_ADD;
      end
      OP_SW:   begin c.alu_src = 1'b1; c.mem_wr = 1'b1; c.ext_op = 1'b1; c.alu_ctr = ALU_ADD; end
      OP_BEQ:  begin c.branch = 1'b1; c.alu_ctr = ALU_SUB; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
    logic ok;
    case (op)
      OP_RTYPE: ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                     (funct == FN_OR)  || (funct == FN_SLT);
      OP_ORI, OP_LW, OP_SW, OP_BEQ: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/inst_decode_if.sv
// Fetch/execute facing bundle of the decode stage. The `illegal` flag exists only
// when ILLEGAL_OP_TRAP_EN is defined.
interface inst_decode_if;
  // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
  // valid never depends on ready, and in_ready depends only on buffer occupancy.
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        br_eq;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  logic        reg_dst;
  logic        alu_src;
  logic        mem_to_reg;
  logic        reg_wr;
  logic        mem_wr;
  logic        branch;
  logic        ext_op;
  logic [2:0]  alu_ctr;
  logic        nPC_sel;
`ifdef ILLEGAL_OP_TRAP_EN
  logic        illegal;
`endif

  modport slave (
    input  in_valid, inst, flush, out_ready, br_eq,
    output in_ready, out_valid, opcode, funct, rs, rt, rd, shamt, imm16,
           reg_dst, alu_src, mem_to_reg, reg_wr, mem_wr, branch, ext_op, alu_ctr, nPC_sel
`ifdef ILLEGAL_OP_TRAP_EN
    , output illegal
`endif
  );

  modport master (
    output in_valid, inst, flush, out_ready, br_eq,
    input  in_ready, out_valid, opcode, funct, rs, rt, rd, shamt, imm16,
           reg_dst, alu_src, mem_to_reg, reg_wr, mem_wr, branch, ext_op, alu_ctr, nPC_sel
`ifdef ILLEGAL_OP_TRAP_EN
    , input illegal
`endif
  );
endinterface

// File: rtl/inst_skid_fifo.sv
// Small circular instruction buffer with synchronous flush; head word is read
// straight from storage so decode sees a registered value.
module inst_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/inst_decode.sv
// Decode stage: buffers fetched words, decodes the head entry and redirects fetch on
// taken beq. Define ILLEGAL_OP_TRAP_EN to add the `illegal` output and trap-flush.
module inst_decode
  import inst_decode_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int INST_W = 32
) (
  input logic          clk,
  input logic          rst_n,
  inst_decode_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]     count;
  logic [INST_W-1:0] head;
  logic              push;
  logic              pop;
  logic              taken;
  logic              fifo_flush;
  ctrl_t             ctrl;

  inst_skid_fifo #(.DEPTH(DEPTH), .W(INST_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (fifo_flush),
    .din   (bus.inst),
    .count (count),
    .head  (head)
  );

  assign bus.in_ready  = (count != CW'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  assign bus.opcode = head[31:26];
  assign bus.rs     = head[25:21];
  assign bus.rt     = head[20:16];
  assign bus.rd     = head[15:11];
  assign bus.shamt  = head[10:6];
  assign bus.funct  = head[5:0];
  assign bus.imm16  = head[15:0];

  // An empty buffer presents a bubble regardless of stale storage contents.
  assign ctrl = bus.out_valid ? decode_ctrl(head[31:26], head[5:0]) : '0;

  assign bus.reg_dst    = ctrl.reg_dst;
  assign bus.alu_src    = ctrl.alu_src;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.reg_wr     = ctrl.reg_wr;
  assign bus.mem_wr     = ctrl.mem_wr;
  assign bus.branch     = ctrl.branch;
  assign bus.ext_op     = ctrl.ext_op;
  assign bus.alu_ctr    = ctrl.alu_ctr;

  // A taken beq consumes the head and discards everything younger as wrong-path.
  assign taken       = pop & ctrl.branch & bus.br_eq & ~bus.flush;
  assign bus.nPC_sel = taken;

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_head;
  assign illegal_head = bus.out_valid & ~is_legal(head[31:26], head[5:0]);
  assign bus.illegal  = illegal_head;
  assign fifo_flush   = bus.flush | taken | (pop & illegal_head);
`else
  assign fifo_flush   = bus.flush | taken;
`endif

endmodule

// File: tb/tb_inst_decode.sv
// Self-checking bench for inst_decode: reference occupancy/order model on a queue,
// directed scenarios followed by constrained-random traffic.
module tb_inst_decode;

  localparam int DEPTH = 2;
  localparam logic [31:0] I_LW   = 32'h8C220004;
  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_ORI  = 32'h3442000F;
  localparam logic [31:0] I_SUB  = 32'h00642822;
  localparam logic [31:0] I_BEQ  = 32'h10220003;
  localparam logic [31:0] I_BAD  = 32'hFC000000;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  logic [31:0] exp_q[$];
  logic [31:0] pool [10];
  logic [9:0]  ctrl_obs;

  inst_decode_if bus ();

  inst_decode #(.DEPTH(DEPTH), .INST_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign ctrl_obs = {bus.reg_dst, bus.alu_src, bus.mem_to_reg, bus.reg_wr, bus.mem_wr,
                     bus.branch, bus.ext_op, bus.alu_ctr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {reg_dst,alu_src,mem_to_reg,reg_wr,mem_wr,branch,ext_op,alu_ctr}
  function automatic logic [9:0] exp_ctrl(input logic [31:0] w);
    case (w[31:26])
      6'h00: case (w[5:0])
        6'h20: return 10'b1001000_010;
        6'h22: return 10'b1001000_110;
        6'h24: return 10'b1001000_000;
        6'h25: return 10'b1001000_001;
        6'h2a: return 10'b1001000_111;
        default: return 10'b0;
      endcase
      6'h0d: return 10'b0101000_001;
      6'h23: return 10'b0111001_010;
      6'h2b: return 10'b0100101_010;
      6'h04: return 10'b0000010_110;
      default: return 10'b0;
    endcase
  endfunction

  function automatic logic exp_legal(input logic [31:0] w);
    if (w[31:26] == 6'h00)
      return (w[5:0] == 6'h20) || (w[5:0] == 6'h22) || (w[5:0] == 6'h24) ||
             (w[5:0] == 6'h25) || (w[5:0] == 6'h2a);
    return (w[31:26] == 6'h0d) || (w[31:26] == 6'h23) || (w[31:26] == 6'h2b) ||
           (w[31:26] == 6'h04);
  endfunction

  // One clock: drive inputs at negedge, check against the model, update the model
  // with what the coming rising edge must do.
  task automatic cycle(input logic v, input logic [31:0] w, input logic ordy,
                       input logic beq, input logic fl);
    int          sz;
    logic [31:0] hw;
    logic        exp_npc;
    logic        kill;
    @(negedge clk);
    bus.in_valid  = v;
    bus.inst      = w;
    bus.out_ready = ordy;
    bus.br_eq     = beq;
    bus.flush     = fl;
    #1;
    sz = exp_q.size();
    hw = (sz != 0) ? exp_q[0] : 32'h0;
    check("in_ready", 32'(bus.in_ready), 32'(sz < DEPTH));
    check("out_valid", 32'(bus.out_valid), 32'(sz != 0));
    if (sz != 0) begin
      check("head_word", {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct}, hw);
      check("imm16", 32'(bus.imm16), 32'(hw[15:0]));
      check("ctrl", 32'(ctrl_obs), 32'(exp_ctrl(hw)));
`ifdef ILLEGAL_OP_TRAP_EN
      check("illegal", 32'(bus.illegal), 32'(!exp_legal(hw)));
`endif
    end
    exp_npc = !fl && ordy && (sz != 0) && (hw[31:26] == 6'h04) && beq;
    check("nPC_sel", 32'(bus.nPC_sel), 32'(exp_npc));
    kill = exp_npc;
`ifdef ILLEGAL_OP_TRAP_EN
    if (ordy && (sz != 0) && !exp_legal(hw)) kill = 1'b1;
`endif
    if (fl) exp_q.delete();
    else begin
      if (ordy && sz != 0) void'(exp_q.pop_front());
      if (kill) exp_q.delete();
      else if (v && sz < DEPTH) exp_q.push_back(w);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    pool = '{I_LW, I_ADD, I_ORI, I_SUB, I_BEQ, 32'hAC450008, 32'h00A62024,
             32'h00A6382A, I_BAD, 32'h08000010};
    rst_n = 1'b0;
    bus.in_valid = 0; bus.inst = 0; bus.out_ready = 0; bus.br_eq = 0; bus.flush = 0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_npc", 32'(bus.nPC_sel), 32'd0);
    check("rst_imm16", 32'(bus.imm16), 32'h0000);
    check("rst_ctrl", 32'(ctrl_obs), 32'd0);
    rst_n = 1'b1;

    // lw held at head until consumed
    cycle(1, I_LW, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("t2_opcode", 32'(bus.opcode), 32'h23);
    check("t2_rs", 32'(bus.rs), 32'd1);
    check("t2_rt", 32'(bus.rt), 32'd2);
    check("t2_imm", 32'(bus.imm16), 32'h0004);
    check("t2_ctrl", 32'(ctrl_obs), 32'(10'b0111001_010));
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);

    // fill, back-pressure, drain in order
    cycle(1, I_ADD, 0, 0, 0);
    cycle(1, I_ORI, 0, 0, 0);
    cycle(1, I_SUB, 0, 0, 0);
    check("t3_full", 32'(bus.in_ready), 32'd0);
    cycle(0, 0, 1, 0, 0);
    check("t3_rd", 32'(bus.rd), 32'd3);
    check("t3_regdst", 32'(bus.reg_dst), 32'd1);
    check("t3_alu", 32'(bus.alu_ctr), 32'b010);
    cycle(0, 0, 1, 0, 0);
    check("t3_ori", 32'(bus.opcode), 32'h0d);

    // taken beq drops younger entries and same-cycle push
    cycle(1, I_BEQ, 0, 0, 0);
    cycle(1, I_ADD, 0, 0, 0);
    cycle(1, I_SUB, 1, 1, 0);
    check("t4_npc", 32'(bus.nPC_sel), 32'd1);
    check("t4_imm", 32'(bus.imm16), 32'h0003);
    cycle(0, 0, 0, 0, 0);
    check("t4_empty", 32'(bus.out_valid), 32'd0);
    check("t4_npc_once", 32'(bus.nPC_sel), 32'd0);

    // not-taken beq
    cycle(1, I_BEQ, 0, 0, 0);
    cycle(1, I_ADD, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    check("t5_npc", 32'(bus.nPC_sel), 32'd0);
    cycle(0, 0, 0, 0, 0);
    check("t5_next", {bus.opcode, bus.funct}, 32'h020);
    cycle(0, 0, 1, 0, 0);

    // external flush dominates push and pop, also suppresses a taken beq
    cycle(1, I_BEQ, 0, 0, 0);
    cycle(1, I_ORI, 0, 0, 0);
    cycle(1, I_SUB, 1, 1, 1);
    check("t6_npc", 32'(bus.nPC_sel), 32'd0);
    cycle(0, 0, 0, 0, 0);
    check("t6_empty", 32'(bus.out_valid), 32'd0);

`ifdef ILLEGAL_OP_TRAP_EN
    cycle(1, I_BAD, 0, 0, 0);
    cycle(1, I_ADD, 0, 0, 0);
    check("t6_illegal", 32'(bus.illegal), 32'd1);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("t6_trap_empty", 32'(bus.out_valid), 32'd0);
`endif

    // asynchronous reset mid-operation
    cycle(1, I_LW, 0, 0, 0);
    cycle(1, I_ADD, 0, 0, 0);
    @(negedge clk);
    bus.in_valid = 0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_ready", 32'(bus.in_ready), 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), pool[$urandom_range(0, 9)],
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 0);
    check("final_empty", 32'(exp_q.size()), 32'd0);
    check("final_valid", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
